puf_challenge_seq: RTL

//  - Sequencer directly upstream of the delay-PUF arbiter chain. Expands one seed into RESP_BITS

---
 rtl/puf_pkg.sv | 34 +++
 rtl/puf_challenge_seq_if.sv | 26 ++
 rtl/puf_lfsr.sv | 43 ++++
 rtl/puf_challenge_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// puf_pkg - shared definitions for the PUF challenge sequencer.
//   ST_* / state_t : FSM encodings (IDLE, ARM, FIRE, SAMPLE, HOLD)
//   DEF_LFSR_MASK  : default Galois tap mask for an 8-bit challenge
//   lfsr_next()    : one Galois LFSR step, evaluated on a LFSR_MAX_W-wide
//                    vector; callers zero-extend and truncate to their width.
package puf_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_FIRE   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ARM    = ST_ARM,
    FIRE   = ST_FIRE,
    SAMPLE = ST_SAMPLE,
    HOLD   = ST_HOLD
  } state_t;

  localparam logic [7:0] DEF_LFSR_MASK = 8'hB8;

  localparam int unsigned LFSR_MAX_W = 64;

  // Galois step: shift right, fold the mask in when the bit shifted out was 1.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] chal,
    input logic [LFSR_MAX_W-1:0] mask
  );
    return (chal >> 1) ^ (chal[0] ? mask : '0);
  endfunction

endpackage

// File: rtl/puf_challenge_seq_if.sv
// puf_challenge_seq_if - response word valid/ready channel.
//   resp_word  : RESP_BITS packed response, bit i = challenge i
//   resp_valid : resp_word is valid, held until accepted
//   resp_ready : consumer accepts on valid & ready
// master modport = sequencer side, slave modport = consumer side.
interface puf_challenge_seq_if #(
  parameter int unsigned RESP_BITS = 8
);

  logic [RESP_BITS-1:0] resp_word;
  logic                 resp_valid;
  logic                 resp_ready;

  modport master (
    output resp_word,
    output resp_valid,
    input  resp_ready
  );

  modport slave (
    input  resp_word,
    input  resp_valid,
    output resp_ready
  );

endinterface

// File: rtl/puf_lfsr.sv
// puf_lfsr - CHAL_W-wide Galois LFSR that generates the PUF challenges.
//   clk, reset : clock, synchronous active-high reset (state -> 0)
//   load       : take seed (a zero seed becomes 1, the all-zero state is stuck)
//   seed       : first challenge
//   step       : advance one Galois step (load has priority)
//   chal       : registered current challenge
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int unsigned       CHAL_W    = 8,
  parameter logic [CHAL_W-1:0] LFSR_MASK = CHAL_W'(DEF_LFSR_MASK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CHAL_W-1:0] seed,
  input  logic              step,
  output logic [CHAL_W-1:0] chal
);

  logic [CHAL_W-1:0] chal_q;
  logic [CHAL_W-1:0] chal_d;

  always_comb begin
    chal_d = chal_q;
    if (load) begin
      chal_d = (seed == '0) ? CHAL_W'(1) : seed;
    end else if (step) begin
      chal_d = CHAL_W'(lfsr_next(LFSR_MAX_W'(chal_q), LFSR_MAX_W'(LFSR_MASK)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chal_q <= '0;
    end else begin
      chal_q <= chal_d;
    end
  end

  assign chal = chal_q;

endmodule

// File: rtl/puf_challenge_seq.sv
// puf_challenge_seq - drives a delay-PUF arbiter chain with RESP_BITS LFSR
// challenges expanded from one seed and packs the sampled results into a
// response word handed out on a valid/ready channel.
//   clk, reset : single clock, synchronous active-high reset
//   start/seed : 1-cycle request, seed sampled with it (0 -> 1); ignored while busy
//   busy       : accepted start .. response handshake
//   puf_chal   : registered challenge, stable while puf_run is high
//   puf_run    : registered run strobe, high SETTLE_CYCLES clocks per evaluation
//   puf_result : synchronised arbiter result, sampled in SAMPLE
//   resp       : puf_challenge_seq_if master (resp_word/resp_valid/resp_ready)
// Each evaluation is ARM (SETTLE_CYCLES) + FIRE (SETTLE_CYCLES) + SAMPLE (1),
// so resp_valid rises RESP_BITS*(2*SETTLE_CYCLES+1) clocks after the start edge.
// Build option PUF_SEQ_VOTE_EN: every challenge is evaluated three times and the
// stored bit is the majority; the LFSR advances only after the third sample.
module puf_challenge_seq
  import puf_pkg::*;
#(
  parameter int unsigned       CHAL_W        = 8,
  parameter int unsigned       RESP_BITS     = 8,
  parameter int unsigned       SETTLE_CYCLES = 8,
  parameter logic [CHAL_W-1:0] LFSR_MASK     = CHAL_W'(DEF_LFSR_MASK)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHAL_W-1:0]   seed,
  output logic                busy,
  output logic [CHAL_W-1:0]   puf_chal,
  output logic                puf_run,
  input  logic                puf_result,
  puf_challenge_seq_if.master resp
);

  localparam int unsigned       CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned       IDX_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(RESP_BITS - 1);

  state_t                state;
  logic [CNT_W-1:0]      settle_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [RESP_BITS-1:0]  word_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  run_q;

  logic                  lfsr_load;
  logic                  lfsr_step;
  logic                  last_eval;   // this SAMPLE completes the current challenge
  logic                  sample_bit;  // value stored into the response word

`ifdef PUF_SEQ_VOTE_EN
  logic [1:0] vote_cnt;
  logic [1:0] ones_cnt;
  logic [1:0] ones_next;

  assign ones_next  = ones_cnt + {1'b0, puf_result};
  assign last_eval  = (vote_cnt == 2'd2);
  // ones_next >= 2 out of 3 samples is the majority
  assign sample_bit = ones_next[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vote_cnt <= '0;
      ones_cnt <= '0;
    end else if (state == IDLE && start) begin
      vote_cnt <= '0;
      ones_cnt <= '0;
    end else if (state == SAMPLE) begin
      if (last_eval) begin
        vote_cnt <= '0;
        ones_cnt <= '0;
      end else begin
        vote_cnt <= vote_cnt + 2'd1;
        ones_cnt <= ones_next;
      end
    end
  end
`else
  assign last_eval  = 1'b1;
  assign sample_bit = puf_result;
`endif

  assign lfsr_load = (state == IDLE) && start;
  assign lfsr_step = (state == SAMPLE) && last_eval;

  puf_lfsr #(
    .CHAL_W    (CHAL_W),
    .LFSR_MASK (LFSR_MASK)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .chal  (puf_chal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      bit_idx    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= ARM;
            settle_cnt <= CNT_LOAD;
            bit_idx    <= '0;
            word_q     <= '0;
            busy_q     <= 1'b1;
          end
        end

        ARM: begin
          if (settle_cnt == '0) begin
            state      <= FIRE;
            settle_cnt <= CNT_LOAD;
            run_q      <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        // run drops on the FIRE exit edge so it is high for exactly SETTLE_CYCLES
        FIRE: begin
          if (settle_cnt == '0) begin
            state      <= SAMPLE;
            settle_cnt <= '0;
            run_q      <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        SAMPLE: begin
          run_q <= 1'b0;
          if (last_eval) begin
            word_q[bit_idx] <= sample_bit;
            if (bit_idx == IDX_LAST) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end else begin
              bit_idx    <= bit_idx + IDX_W'(1);
              state      <= ARM;
              settle_cnt <= CNT_LOAD;
            end
          end else begin
            state      <= ARM;
            settle_cnt <= CNT_LOAD;
          end
        end

        HOLD: begin
          if (resp.resp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign puf_run         = run_q;
  assign resp.resp_word  = word_q;
  assign resp.resp_valid = valid_q;

endmodule
